// File: rtl/mem_responder_if.sv
// Request/response bundle between the lime control FSM/datapath and the memory responder.
// Carries the read/write strobes, address, store data and the completion/status returns.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  MemR;
    logic                  MemW;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  Ready;
    logic                  Busy;
    logic                  Error;

    // Handshake: a request is taken on a rising edge where MemR|MemW is high and the
    // responder is idle (Busy low). Strobes seen while Busy are dropped, so the master
    // holds or re-issues them. Completion is a single-cycle Ready; Error qualifies it.
    modport master (
        output MemR, MemW, Addr, WriteData,
        input  ReadData, Ready, Busy, Error
    );

    modport slave (
        input  MemR, MemW, Addr, WriteData,
        output ReadData, Ready, Busy, Error
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: owns the unified instruction/data array, inserts WAIT_CYCLES
// wait states per request and reports completion with a one-cycle Ready pulse.
module mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    mem_responder_if.slave        bus,
    output logic [1:0]            fsm_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic                  req_rd;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  access;
    logic                  acc_rd;
    logic                  acc_wr;
    logic                  acc_illegal;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [IDX_W-1:0]      acc_idx;

    assign accept = (state == S_IDLE) && (bus.MemR || bus.MemW);
    // The array is touched on the edge that enters RESP, from IDLE or from WAIT.
    assign access = (state_next == S_RESP);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (bus.MemR || bus.MemW) state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.Ready = (state == S_RESP);
        bus.Busy  = (state != S_IDLE);
        bus.Error = (state == S_RESP) && err_q;
        fsm_state = state;
    end

    assign bus.ReadData = rdata_q;

    // With zero wait states the access coincides with acceptance, so the live inputs
    // are used; otherwise the copy latched at acceptance is.
    always_comb begin
        if (state == S_IDLE) begin
            acc_rd    = bus.MemR;
            acc_wr    = bus.MemW;
            acc_addr  = bus.Addr;
            acc_wdata = bus.WriteData;
        end else begin
            acc_rd    = req_rd;
            acc_wr    = req_wr;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
        acc_idx     = acc_addr[IDX_W-1:0];
        acc_illegal = (acc_rd && acc_wr) || (32'(acc_addr) >= DEPTH);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt       <= 4'd0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                cnt       <= CNT_LOAD;
                req_rd    <= bus.MemR;
                req_wr    <= bus.MemW;
                req_addr  <= bus.Addr;
                req_wdata <= bus.WriteData;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err_q <= acc_illegal;
                if (acc_rd) begin
                    rdata_q <= acc_illegal ? '0 : mem[acc_idx];
                end
            end
        end
    end

    // Array is never cleared; a reset on the would-be commit edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (!Reset && access && acc_wr && !acc_illegal) begin
            mem[acc_idx] <= acc_wdata;
        end
    end
endmodule
